// File: rtl/irq_ack_responder_if.sv
// Request/ack handshake between an interrupt requester (master) and the host
// responder (slave).
interface irq_ack_responder_if;
  logic       irq_req_vld;
  logic [4:0] irq_req_vec;
  logic [7:0] irq_req_fnc;
  logic       irq_ack;
  logic [4:0] irq_ack_vec;
  logic       irq_fail;

  modport master (
    output irq_req_vld, irq_req_vec, irq_req_fnc,
    input  irq_ack, irq_ack_vec, irq_fail
  );

  modport slave (
    input  irq_req_vld, irq_req_vec, irq_req_fnc,
    output irq_ack, irq_ack_vec, irq_fail
  );
endinterface

// File: rtl/irq_ack_responder.sv
// Host-side interrupt responder: one outstanding request, programmable latency,
// single ack/fail strobe, per-vector gating, saturating stats, sticky protocol error.
//
// state | meaning
// IDLE  | no request in flight, waiting for irq_req_vld
// WAIT  | request captured, latency down-counter running
// RESP  | one-cycle ack or fail strobe on the bus
// GAP   | one-cycle turnaround, requester input ignored
module irq_ack_responder #(
  parameter int NUM_VEC = 16,
  parameter int LAT_W   = 8,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  irq_ack_responder_if.slave   bus,
  input  logic [LAT_W-1:0]     cfg_lat,
  input  logic [NUM_VEC-1:0]   cfg_vec_en,
  input  logic                 cfg_force_fail,
  input  logic                 clr_stats,
  output logic [CNT_W-1:0]     ack_cnt,
  output logic [CNT_W-1:0]     fail_cnt,
  output logic [7:0]           last_fnc,
  output logic                 proto_err,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP, GAP} state_t;

  state_t           state;
  logic [LAT_W-1:0] lat_cnt;
  logic [4:0]       cap_vec;
  logic [7:0]       cap_fnc;
  logic             cap_fail;

  logic [31:0] vec_en_ext;
  logic        req_fail;
  logic        req_mismatch;

  // Zero-extending the enable mask keeps the lookup in range for any 5-bit vector.
  assign vec_en_ext   = 32'(cfg_vec_en);
  assign req_fail     = cfg_force_fail
                     || (32'(bus.irq_req_vec) >= 32'(NUM_VEC))
                     || !vec_en_ext[bus.irq_req_vec];
  assign req_mismatch = !bus.irq_req_vld
                     || (bus.irq_req_vec != cap_vec)
                     || (bus.irq_req_fnc != cap_fnc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      lat_cnt         <= '0;
      cap_vec         <= '0;
      cap_fnc         <= '0;
      cap_fail        <= 1'b0;
      bus.irq_ack     <= 1'b0;
      bus.irq_fail    <= 1'b0;
      bus.irq_ack_vec <= '0;
      ack_cnt         <= '0;
      fail_cnt        <= '0;
      last_fnc        <= '0;
      proto_err       <= 1'b0;
      busy            <= 1'b0;
    end else begin
      bus.irq_ack     <= 1'b0;
      bus.irq_fail    <= 1'b0;
      bus.irq_ack_vec <= '0;
      case (state)
        IDLE: begin
          if (bus.irq_req_vld) begin
            cap_vec  <= bus.irq_req_vec;
            cap_fnc  <= bus.irq_req_fnc;
            cap_fail <= req_fail;
            last_fnc <= bus.irq_req_fnc;
            busy     <= 1'b1;
            // Zero latency skips WAIT so the strobe lands the cycle after capture.
            if (cfg_lat == '0) begin
              state           <= RESP;
              bus.irq_ack     <= !req_fail;
              bus.irq_fail    <= req_fail;
              bus.irq_ack_vec <= bus.irq_req_vec;
            end else begin
              state   <= WAIT;
              lat_cnt <= cfg_lat - LAT_W'(1);
            end
          end
        end
        WAIT: begin
          if (req_mismatch) begin
            proto_err <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (lat_cnt == '0) begin
            state           <= RESP;
            bus.irq_ack     <= !cap_fail;
            bus.irq_fail    <= cap_fail;
            bus.irq_ack_vec <= cap_vec;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        RESP: begin
          state <= GAP;
          if (cap_fail) begin
            if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
          end else begin
            if (ack_cnt != '1) ack_cnt <= ack_cnt + CNT_W'(1);
          end
        end
        GAP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
      // Clear overrides any increment or error set in the same cycle.
      if (clr_stats) begin
        ack_cnt   <= '0;
        fail_cnt  <= '0;
        proto_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_irq_ack_responder.sv
// Self-checking bench for irq_ack_responder: directed scenarios plus randomized
// transactions against a cycle-count reference model.
module tb_irq_ack_responder;
  localparam int NUM_VEC = 16;
  localparam int LAT_W   = 8;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;

  logic               clk;
  logic               rst_n;
  logic [LAT_W-1:0]   cfg_lat;
  logic [NUM_VEC-1:0] cfg_vec_en;
  logic               cfg_force_fail;
  logic               clr_stats;
  logic [CNT_W-1:0]   ack_cnt;
  logic [CNT_W-1:0]   fail_cnt;
  logic [7:0]         last_fnc;
  logic               proto_err;
  logic               busy;

  int total = 0;
  int bad   = 0;
  int exp_ack_cnt  = 0;
  int exp_fail_cnt = 0;
  int exp_proto    = 0;

  irq_ack_responder_if bus ();

  irq_ack_responder #(.NUM_VEC(NUM_VEC), .LAT_W(LAT_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .cfg_lat        (cfg_lat),
    .cfg_vec_en     (cfg_vec_en),
    .cfg_force_fail (cfg_force_fail),
    .clr_stats      (clr_stats),
    .ack_cnt        (ack_cnt),
    .fail_cnt       (fail_cnt),
    .last_fnc       (last_fnc),
    .proto_err      (proto_err),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sat_inc(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  function automatic bit model_fail(input logic [4:0] vec, input logic [15:0] en, input logic ff);
    return ff || (int'(vec) >= NUM_VEC) || (((en >> vec) & 16'h1) == 16'h0);
  endfunction

  task automatic check_all_zero(input string name);
    total++;
    if ({bus.irq_ack, bus.irq_fail, bus.irq_ack_vec, ack_cnt, fail_cnt,
         last_fnc, proto_err, busy} !== '0) begin
      bad++;
      $display("FAIL %s got ack=%b fail=%b vec=%0d acnt=%0d fcnt=%0d fnc=%h perr=%b busy=%b, exp all zero",
               name, bus.irq_ack, bus.irq_fail, bus.irq_ack_vec, ack_cnt, fail_cnt,
               last_fnc, proto_err, busy);
    end
  endtask

  task automatic check_stats(input string name);
    total++;
    if (ack_cnt !== CNT_W'(exp_ack_cnt) || fail_cnt !== CNT_W'(exp_fail_cnt) ||
        proto_err !== 1'(exp_proto)) begin
      bad++;
      $display("FAIL %s got acnt=%0d fcnt=%0d perr=%b exp acnt=%0d fcnt=%0d perr=%0d",
               name, ack_cnt, fail_cnt, proto_err, exp_ack_cnt, exp_fail_cnt, exp_proto);
    end
  endtask

  task automatic check_quiet(input string name, input logic exp_busy);
    total++;
    if (bus.irq_ack !== 1'b0 || bus.irq_fail !== 1'b0 || bus.irq_ack_vec !== 5'd0 ||
        busy !== exp_busy) begin
      bad++;
      $display("FAIL %s got ack=%b fail=%b vec=%0d busy=%b exp ack=0 fail=0 vec=0 busy=%b",
               name, bus.irq_ack, bus.irq_fail, bus.irq_ack_vec, busy, exp_busy);
    end
  endtask

  // One full request: capture, latency, strobe, gap, back to idle.
  task automatic do_txn(input logic [4:0] vec, input logic [7:0] fnc, input logic [7:0] lat,
                        input logic [15:0] en, input logic ff, input bit clr_at_resp);
    bit exp_fail;
    bit strobe;
    exp_fail        = model_fail(vec, en, ff);
    cfg_lat         = lat;
    cfg_vec_en      = en;
    cfg_force_fail  = ff;
    bus.irq_req_vld = 1'b1;
    bus.irq_req_vec = vec;
    bus.irq_req_fnc = fnc;
    for (int i = 1; i <= int'(lat) + 1; i++) begin
      @(negedge clk);
      cfg_lat        = 8'($urandom);
      cfg_vec_en     = 16'($urandom);
      cfg_force_fail = 1'($urandom);
      strobe = (i == int'(lat) + 1);
      total++;
      if (bus.irq_ack !== (strobe && !exp_fail) || bus.irq_fail !== (strobe && exp_fail) ||
          bus.irq_ack_vec !== (strobe ? vec : 5'd0) || busy !== 1'b1) begin
        bad++;
        $display("FAIL txn_strobe cyc=%0d lat=%0d got ack=%b fail=%b vec=%0d busy=%b exp ack=%b fail=%b vec=%0d busy=1",
                 i, lat, bus.irq_ack, bus.irq_fail, bus.irq_ack_vec, busy,
                 strobe && !exp_fail, strobe && exp_fail, strobe ? vec : 5'd0);
      end
      if (i == 1) begin
        total++;
        if (last_fnc !== fnc) begin
          bad++;
          $display("FAIL last_fnc got=%h exp=%h", last_fnc, fnc);
        end
      end
      if (strobe) begin
        bus.irq_req_vld = 1'b0;
        if (clr_at_resp) begin
          clr_stats    = 1'b1;
          exp_ack_cnt  = 0;
          exp_fail_cnt = 0;
          exp_proto    = 0;
        end else if (exp_fail) begin
          exp_fail_cnt = sat_inc(exp_fail_cnt);
        end else begin
          exp_ack_cnt = sat_inc(exp_ack_cnt);
        end
      end
    end
    @(negedge clk);
    clr_stats = 1'b0;
    check_quiet("txn_gap", 1'b1);
    check_stats("txn_stats");
    @(negedge clk);
    check_quiet("txn_idle", 1'b0);
  endtask

  task automatic test_reset();
    rst_n           = 1'b0;
    bus.irq_req_vld = 1'b0;
    bus.irq_req_vec = '0;
    bus.irq_req_fnc = '0;
    cfg_lat         = '0;
    cfg_vec_en      = '0;
    cfg_force_fail  = 1'b0;
    clr_stats       = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_held");
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("reset_release");
  endtask

  task automatic test_basic();
    do_txn(5'd5, 8'h12, 8'd0, 16'hFFFF, 1'b0, 1'b0);
  endtask

  task automatic test_vec_gating();
    do_txn(5'd0, 8'h21, 8'd4, 16'h55AA, 1'b0, 1'b0);
    do_txn(5'd1, 8'h22, 8'd4, 16'h55AA, 1'b0, 1'b0);
  endtask

  task automatic test_fail_paths();
    do_txn(5'd20, 8'h30, 8'd2, 16'hFFFF, 1'b0, 1'b0);
    do_txn(5'd3,  8'h31, 8'd1, 16'hFFFF, 1'b1, 1'b0);
    do_txn(5'd31, 8'h32, 8'd0, 16'hFFFF, 1'b0, 1'b0);
  endtask

  // Requester breaks the handshake d cycles into a WAIT of length lat.
  task automatic test_proto(input int lat, input int d, input int mode);
    cfg_lat         = 8'(lat);
    cfg_vec_en      = '1;
    cfg_force_fail  = 1'b0;
    bus.irq_req_vld = 1'b1;
    bus.irq_req_vec = 5'($urandom_range(0, 15));
    bus.irq_req_fnc = 8'($urandom);
    for (int i = 1; i <= d; i++) begin
      @(negedge clk);
      check_quiet("proto_wait", 1'b1);
    end
    case (mode)
      0:       bus.irq_req_vld = 1'b0;
      1:       bus.irq_req_vec = bus.irq_req_vec ^ 5'($urandom_range(1, 31));
      default: bus.irq_req_fnc = bus.irq_req_fnc ^ 8'($urandom_range(1, 255));
    endcase
    @(negedge clk);
    bus.irq_req_vld = 1'b0;
    exp_proto = 1;
    check_quiet("proto_abort", 1'b0);
    check_stats("proto_err_set");
    for (int i = 0; i < lat + 3; i++) begin
      @(negedge clk);
      check_quiet("proto_no_strobe", 1'b0);
    end
    clr_stats = 1'b1;
    @(negedge clk);
    clr_stats    = 1'b0;
    exp_ack_cnt  = 0;
    exp_fail_cnt = 0;
    exp_proto    = 0;
    check_stats("proto_clr");
  endtask

  task automatic test_back_to_back();
    int n_ack;
    n_ack = 0;
    clr_stats = 1'b1;
    @(negedge clk);
    clr_stats    = 1'b0;
    exp_ack_cnt  = 0;
    exp_fail_cnt = 0;
    exp_proto    = 0;
    cfg_lat         = '0;
    cfg_vec_en      = '1;
    cfg_force_fail  = 1'b0;
    bus.irq_req_vld = 1'b1;
    bus.irq_req_vec = 5'd9;
    bus.irq_req_fnc = 8'($urandom);
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      total++;
      if (bus.irq_ack !== (i % 3 == 1) || bus.irq_fail !== 1'b0 ||
          bus.irq_ack_vec !== ((i % 3 == 1) ? 5'd9 : 5'd0)) begin
        bad++;
        $display("FAIL b2b_strobe cyc=%0d got ack=%b fail=%b vec=%0d exp ack=%b fail=0",
                 i, bus.irq_ack, bus.irq_fail, bus.irq_ack_vec, (i % 3 == 1));
      end
      if (i % 3 == 1) n_ack++;
    end
    bus.irq_req_vld = 1'b0;
    exp_ack_cnt = (n_ack > CNT_MAX) ? CNT_MAX : n_ack;
    @(negedge clk);
    check_stats("b2b_saturate");
    @(negedge clk);
    check_quiet("b2b_idle", 1'b0);
  endtask

  task automatic test_clr_collide();
    do_txn(5'd7, 8'h44, 8'd2, 16'hFFFF, 1'b0, 1'b0);
    do_txn(5'd7, 8'h45, 8'd2, 16'hFFFF, 1'b0, 1'b1);
  endtask

  task automatic test_reset_midflight();
    cfg_lat         = 8'd8;
    cfg_vec_en      = '1;
    cfg_force_fail  = 1'b0;
    bus.irq_req_vld = 1'b1;
    bus.irq_req_vec = 5'd2;
    bus.irq_req_fnc = 8'h5C;
    repeat (3) begin
      @(negedge clk);
      check_quiet("rst_mid_wait", 1'b1);
    end
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid_async");
    repeat (3) begin
      @(negedge clk);
      check_all_zero("rst_mid_held");
    end
    bus.irq_req_vld = 1'b0;
    rst_n = 1'b1;
    exp_ack_cnt  = 0;
    exp_fail_cnt = 0;
    exp_proto    = 0;
    repeat (12) begin
      @(negedge clk);
      check_quiet("rst_mid_silent", 1'b0);
    end
    check_stats("rst_mid_stats");
    do_txn(5'd2, 8'h5D, 8'd3, 16'hFFFF, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      do_txn(5'($urandom_range(0, 31)), 8'($urandom), 8'($urandom_range(0, 6)),
             16'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 9) == 0));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vec_gating();
    test_fail_paths();
    test_proto(10, 3, 0);
    for (int k = 0; k < 6; k++) begin
      int lat_r;
      lat_r = $urandom_range(1, 8);
      test_proto(lat_r, $urandom_range(1, lat_r), k % 3);
    end
    test_back_to_back();
    test_clr_collide();
    test_reset_midflight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
